thread_scheduler: RTL and testbench

//  Barrel-thread issue scheduler for the hart core. Issues one thread slot per cycle, round-robin over NUM_THREADS.

---
 rtl/thread_scheduler_pkg.sv | 29 ++
 rtl/thread_index_pipe.sv | 56 +++++
 rtl/thread_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_thread_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// thread_scheduler_pkg
//   Shared types for the barrel-thread issue scheduler.
//   - sched_state_t : scheduler sequencing states
//   - thread_cmd_t  : encoding of the i_cmd_op thread command field
//   - sched_wait_width() : width of the INIT/DRAIN wait counter
// -----------------------------------------------------------------------------
package thread_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_INIT,
    SCHED_RUN,
    SCHED_DRAIN,
    SCHED_HALTED
  } sched_state_t;

  typedef enum logic [1:0] {
    CMD_NOP,
    CMD_START,
    CMD_STOP,
    CMD_RSVD
  } thread_cmd_t;

  // The wait counter must reach EXE_STAGE+1 (the longest wait, in INIT).
  function automatic int unsigned sched_wait_width(input int unsigned exe_stage);
    return $clog2(exe_stage + 2);
  endfunction

endpackage : thread_scheduler_pkg

// File: rtl/thread_index_pipe.sv
// -----------------------------------------------------------------------------
// thread_index_pipe
//   Fixed-latency {index, valid} delay line. The output pair is the input pair
//   from exactly DEPTH clock cycles earlier. Asynchronous reset clears every
//   stage, so no stale valid can emerge after reset.
// Ports
//   clk      in   1       clock, posedge
//   reset    in   1       asynchronous, active-high
//   i_index  in   WIDTH   index entering the line
//   i_valid  in   1       valid entering the line
//   o_index  out  WIDTH   index delayed DEPTH cycles
//   o_valid  out  1       valid delayed DEPTH cycles
// -----------------------------------------------------------------------------
module thread_index_pipe #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_index,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_index,
  output logic             o_valid
);

  logic [WIDTH-1:0] index_q [DEPTH];
  logic [WIDTH-1:0] index_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    index_d[0] = i_index;
    valid_d    = '0;
    valid_d[0] = i_valid;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      index_d[i] = index_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        index_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  assign o_index = index_q[DEPTH-1];
  assign o_valid = valid_q[DEPTH-1];

endmodule : thread_index_pipe

// File: rtl/thread_scheduler.sv
// -----------------------------------------------------------------------------
// thread_scheduler
//   Barrel-thread issue scheduler. A free-running slot counter selects one
//   thread per cycle (round-robin over NUM_THREADS) and doubles as the PC file
//   read index; the same index delayed EXE_STAGE cycles is the PC write-back
//   index. Issue is gated by a per-thread active mask updated by START/STOP
//   commands, and by the sequencing FSM (INIT -> RUN <-> DRAIN -> HALTED).
// Ports
//   clk                     in   1        clock, posedge
//   reset                   in   1        asynchronous, active-high
//   i_cmd_valid             in   1        thread command request
//   o_cmd_ready             out  1        command accepted when valid && ready
//   i_cmd_op                in   2        NOP / START / STOP / reserved (NOP)
//   i_cmd_thread            in   IDX      target thread of the command
//   i_halt_all              in   1        level, request global halt
//   i_resume                in   1        pulse, leave HALTED
//   o_thread_index_counter  out  IDX      issue slot (PC file read index)
//   o_issue_valid           out  1        slot carries a live instruction
//   o_thread_index_execute  out  IDX      slot delayed EXE_STAGE (write index)
//   o_exe_valid             out  1        issue valid delayed EXE_STAGE
//   o_active_mask           out  NT       current active mask
//   o_halted                out  1        scheduler is HALTED
// -----------------------------------------------------------------------------
module thread_scheduler
  import thread_scheduler_pkg::*;
#(
  parameter int unsigned                NUM_THREADS = 16,
  parameter int unsigned                EXE_STAGE   = 7,
  parameter logic [NUM_THREADS-1:0]     BOOT_MASK   = NUM_THREADS'(1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [1:0]                     i_cmd_op,
  input  logic [$clog2(NUM_THREADS)-1:0] i_cmd_thread,
  input  logic                           i_halt_all,
  input  logic                           i_resume,
  output logic [$clog2(NUM_THREADS)-1:0] o_thread_index_counter,
  output logic                           o_issue_valid,
  output logic [$clog2(NUM_THREADS)-1:0] o_thread_index_execute,
  output logic                           o_exe_valid,
  output logic [NUM_THREADS-1:0]         o_active_mask,
  output logic                           o_halted
);

  localparam int unsigned IDX_W  = $clog2(NUM_THREADS);
  localparam int unsigned WAIT_W = sched_wait_width(EXE_STAGE);

  // INIT lasts EXE_STAGE+2 cycles, DRAIN lasts EXE_STAGE+1 cycles; the wait
  // counter starts at 0 on entry, so the last cycle is one less than the length.
  localparam logic [WAIT_W-1:0] INIT_LAST  = WAIT_W'(EXE_STAGE + 1);
  localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(EXE_STAGE);

  sched_state_t           state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [IDX_W-1:0]       counter_q, counter_d;
  logic [NUM_THREADS-1:0] mask_q, mask_d;
  logic                   issue_valid_q, issue_valid_d;
  logic                   cmd_fire;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCHED_INIT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      SCHED_INIT: begin
        // Give the PC file time to be loaded with the startup address.
        if (wait_q == INIT_LAST) begin
          state_d = SCHED_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SCHED_RUN: begin
        if (i_halt_all) begin
          state_d = SCHED_DRAIN;
          wait_d  = '0;
        end
      end
      SCHED_DRAIN: begin
        // Wait until every slot issued in RUN has left the execute pipe.
        if (wait_q == DRAIN_LAST) begin
          state_d = SCHED_HALTED;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      SCHED_HALTED: begin
        // A held halt request wins over resume.
        if (!i_halt_all && i_resume) begin
          state_d = SCHED_RUN;
        end
      end
      default: begin
        state_d = SCHED_INIT;
        wait_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    o_cmd_ready = 1'b0;
    o_halted    = 1'b0;
    unique case (state_q)
      SCHED_RUN:    o_cmd_ready = 1'b1;
      SCHED_HALTED: begin
        o_cmd_ready = 1'b1;
        o_halted    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot counter, active mask and issue valid
  // ---------------------------------------------------------------------------
  assign cmd_fire = i_cmd_valid && o_cmd_ready;

  always_comb begin
    // Free-running; natural overflow provides the NT-1 -> 0 wrap.
    counter_d = counter_q + 1'b1;

    mask_d = mask_q;
    if (cmd_fire) begin
      unique case (thread_cmd_t'(i_cmd_op))
        CMD_START: mask_d[i_cmd_thread] = 1'b1;
        CMD_STOP:  mask_d[i_cmd_thread] = 1'b0;
        default:   ;
      endcase
    end

    // Registered from next-cycle terms so issue valid lines up with the
    // counter value it belongs to; a command accepted in this cycle therefore
    // affects only later slots.
    issue_valid_d = (state_d == SCHED_RUN) && mask_d[counter_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q     <= '0;
      mask_q        <= BOOT_MASK;
      issue_valid_q <= 1'b0;
    end else begin
      counter_q     <= counter_d;
      mask_q        <= mask_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign o_thread_index_counter = counter_q;
  assign o_issue_valid          = issue_valid_q;
  assign o_active_mask          = mask_q;

  // ---------------------------------------------------------------------------
  // Issue -> execute delay line (PC write-back index)
  // ---------------------------------------------------------------------------
  thread_index_pipe #(
    .DEPTH (EXE_STAGE),
    .WIDTH (IDX_W)
  ) u_index_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_index (counter_q),
    .i_valid (issue_valid_q),
    .o_index (o_thread_index_execute),
    .o_valid (o_exe_valid)
  );

endmodule : thread_scheduler

// File: tb/tb_thread_scheduler.sv
// -----------------------------------------------------------------------------
// tb_thread_scheduler
//   Directed bench for thread_scheduler (NT=16, EXE_STAGE=7, BOOT_MASK=1).
//   Cycle numbers in comments count clock edges since reset release.
// -----------------------------------------------------------------------------
module tb_thread_scheduler;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_thread;
  logic        halt_all;
  logic        resume;
  logic [3:0]  idx_cnt;
  logic        issue_valid;
  logic [3:0]  idx_exe;
  logic        exe_valid;
  logic [15:0] mask;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  thread_scheduler #(
    .NUM_THREADS (16),
    .EXE_STAGE   (7),
    .BOOT_MASK   (16'h0001)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .i_cmd_valid            (cmd_valid),
    .o_cmd_ready            (cmd_ready),
    .i_cmd_op               (cmd_op),
    .i_cmd_thread           (cmd_thread),
    .i_halt_all             (halt_all),
    .i_resume               (resume),
    .o_thread_index_counter (idx_cnt),
    .o_issue_valid          (issue_valid),
    .o_thread_index_execute (idx_exe),
    .o_exe_valid            (exe_valid),
    .o_active_mask          (mask),
    .o_halted               (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [1:0] op;
    logic [3:0] th;
    logic       halt;
    logic       res;
    int         cnt;
    int         iv;
    int         xidx;
    int         xv;
    int         msk;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " counter"},     int'(idx_cnt),     0);
    chk({tag, " issue_valid"}, int'(issue_valid), 0);
    chk({tag, " exe_index"},   int'(idx_exe),     0);
    chk({tag, " exe_valid"},   int'(exe_valid),   0);
    chk({tag, " mask"},        int'(mask),        1);
    chk({tag, " halted"},      int'(halted),      0);
    chk({tag, " cmd_ready"},   int'(cmd_ready),   0);
  endtask

  // Boot with only thread 0 active: INIT for cycles 0..8, first issue at
  // cycle 16 (slot 0), execute pulse 7 cycles after each issue.
  task automatic check_boot(input int last);
    for (int c = 0; c <= last; c++) begin
      chk($sformatf("boot counter c%0d", c), int'(idx_cnt), c % 16);
      chk($sformatf("boot issue c%0d", c), int'(issue_valid),
          int'(c >= 9 && (c % 16) == 0));
      chk($sformatf("boot exe_valid c%0d", c), int'(exe_valid),
          int'(c == 23 || c == 39));
      chk($sformatf("boot exe_index c%0d", c), int'(idx_exe),
          (c >= 7) ? (c - 7) % 16 : 0);
      chk($sformatf("boot ready c%0d", c), int'(cmd_ready), int'(c >= 9));
      chk($sformatf("boot mask c%0d", c), int'(mask), 1);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cv op th halt res | cnt iv xidx xv mask  (cycles 81..101)
    tbl[0]  = '{1'b1, 2'd1, 4'd5, 1'b0, 1'b0,  1, 0, 10, 0, 16'h8009}; // START 5
    tbl[1]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  2, 0, 11, 0, 16'h8029};
    tbl[2]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  3, 1, 12, 0, 16'h8029};
    tbl[3]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  4, 0, 13, 0, 16'h8029};
    tbl[4]  = '{1'b1, 2'd2, 4'd5, 1'b0, 1'b0,  5, 1, 14, 0, 16'h8029}; // STOP 5 in slot 5
    tbl[5]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  6, 0, 15, 1, 16'h8009};
    tbl[6]  = '{1'b1, 2'd3, 4'd7, 1'b0, 1'b0,  7, 0,  0, 1, 16'h8009}; // reserved op
    tbl[7]  = '{1'b1, 2'd1, 4'd3, 1'b0, 1'b0,  8, 0,  1, 0, 16'h8009}; // START active 3
    tbl[8]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b1,  9, 0,  2, 0, 16'h8009}; // resume in RUN
    tbl[9]  = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 10, 0,  3, 1, 16'h8009};
    tbl[10] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 11, 0,  4, 0, 16'h8009};
    tbl[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 12, 0,  5, 1, 16'h8009};
    tbl[12] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 13, 0,  6, 0, 16'h8009};
    tbl[13] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 14, 0,  7, 0, 16'h8009};
    tbl[14] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 15, 1,  8, 0, 16'h8009};
    tbl[15] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  0, 1,  9, 0, 16'h8009};
    tbl[16] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  1, 0, 10, 0, 16'h8009};
    tbl[17] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  2, 0, 11, 0, 16'h8009};
    tbl[18] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  3, 1, 12, 0, 16'h8009};
    tbl[19] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  4, 0, 13, 0, 16'h8009};
    tbl[20] = '{1'b0, 2'd0, 4'd0, 1'b0, 1'b0,  5, 0, 14, 0, 16'h8009}; // slot 5 bubble

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 2'd0;
    cmd_thread = 4'd0;
    halt_all   = 1'b0;
    resume     = 1'b0;

    // Reset values, then boot sequence (cycles 0..40)
    tick();
    check_reset("reset");
    reset = 1'b0;
    check_boot(40);

    // cycle 41: START 3, cycle 42: START 15
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_thread = 4'd3;
    tick();
    cmd_thread = 4'd15;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'd0;
    chk("mask after START 3,15", int'(mask), 16'h8009);
    for (int c = 43; c <= 80; c++) begin
      int s;
      int xs;
      s  = c % 16;
      xs = (c - 7) % 16;
      chk($sformatf("rr counter c%0d", c), int'(idx_cnt), s);
      chk($sformatf("rr issue c%0d", c), int'(issue_valid),
          int'(s == 0 || s == 3 || s == 15));
      chk($sformatf("rr exe_index c%0d", c), int'(idx_exe), xs);
      if (c >= 50)
        chk($sformatf("rr exe_valid c%0d", c), int'(exe_valid),
            int'(xs == 0 || xs == 3 || xs == 15));
      tick();
    end

    // cycles 81..101: table of command corner cases
    for (int r = 0; r < 21; r++) begin
      cmd_valid  = tbl[r].cv;
      cmd_op     = tbl[r].op;
      cmd_thread = tbl[r].th;
      halt_all   = tbl[r].halt;
      resume     = tbl[r].res;
      chk($sformatf("vec%0d counter", r),   int'(idx_cnt),     tbl[r].cnt);
      chk($sformatf("vec%0d issue", r),     int'(issue_valid), tbl[r].iv);
      chk($sformatf("vec%0d exe_index", r), int'(idx_exe),     tbl[r].xidx);
      chk($sformatf("vec%0d exe_valid", r), int'(exe_valid),   tbl[r].xv);
      chk($sformatf("vec%0d mask", r),      int'(mask),        tbl[r].msk);
      chk($sformatf("vec%0d ready", r),     int'(cmd_ready),   1);
      chk($sformatf("vec%0d halted", r),    int'(halted),      0);
      tick();
    end
    cmd_valid = 1'b0; cmd_op = 2'd0; resume = 1'b0;

    // cycles 102..117: START every thread
    for (int t = 0; t < 16; t++) begin
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_thread = 4'(t);
      tick();
    end
    cmd_valid = 1'b0; cmd_op = 2'd0;
    chk("mask all active", int'(mask), 16'hFFFF);
    for (int c = 118; c <= 125; c++) begin
      chk($sformatf("full issue c%0d", c), int'(issue_valid), 1);
      tick();
    end

    // cycle 126: halt request; last issue happens this cycle
    chk("issue before halt", int'(issue_valid), 1);
    halt_all = 1'b1;
    tick();

    // cycles 127..134: DRAIN; STOP 2 presented but held off
    for (int c = 127; c <= 134; c++) begin
      chk($sformatf("drain issue c%0d", c), int'(issue_valid), 0);
      chk($sformatf("drain ready c%0d", c), int'(cmd_ready), 0);
      chk($sformatf("drain halted c%0d", c), int'(halted), 0);
      chk($sformatf("drain exe_valid c%0d", c), int'(exe_valid), int'(c <= 133));
      chk($sformatf("drain mask c%0d", c), int'(mask), 16'hFFFF);
      if (c == 127) begin
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_thread = 4'd2;
      end
      tick();
    end

    // cycle 135: HALTED, held STOP 2 accepted now
    chk("halted rise", int'(halted), 1);
    chk("halted ready", int'(cmd_ready), 1);
    chk("halted exe_valid", int'(exe_valid), 0);
    chk("halted mask pre", int'(mask), 16'hFFFF);
    tick();

    // cycle 136: resume while halt still held
    chk("halted mask post STOP 2", int'(mask), 16'hFFFB);
    chk("halted still c136", int'(halted), 1);
    cmd_valid = 1'b0; cmd_op = 2'd0;
    resume = 1'b1;
    tick();

    // cycle 137: halt has priority, still HALTED; now drop halt
    chk("halt priority over resume", int'(halted), 1);
    chk("halted issue c137", int'(issue_valid), 0);
    halt_all = 1'b0;
    tick();

    // cycle 138: back in RUN at the current slot
    chk("resume halted", int'(halted), 0);
    chk("resume counter", int'(idx_cnt), 10);
    chk("resume issue", int'(issue_valid), 1);
    chk("resume ready", int'(cmd_ready), 1);
    resume = 1'b0;
    tick();
    for (int c = 139; c <= 146; c++) begin
      chk($sformatf("post counter c%0d", c), int'(idx_cnt), c % 16);
      chk($sformatf("post issue c%0d", c), int'(issue_valid), int'((c % 16) != 2));
      chk($sformatf("post exe_valid c%0d", c), int'(exe_valid), int'(c >= 145));
      chk($sformatf("post exe_index c%0d", c), int'(idx_exe), (c - 7) % 16);
      tick();
    end

    // Mid-run asynchronous reset, checked between clock edges
    #2;
    reset = 1'b1;
    #1;
    check_reset("async reset");
    tick();
    reset = 1'b0;
    check_boot(23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_thread_scheduler
